// File: rtl/ram_o9_ctrl.sv
// Single-port O9 data/instruction RAM with valid/ready requests, per-byte writes and optional clear sweep.
// Latency: READ_LATENCY (1 or 2) cycles from acceptance to the registered response; one request per cycle.
// Backpressure: req_ready is low only while the post-reset clear sweep runs; responses cannot be stalled.
module ram_o9_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wren,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        clear_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  logic                    s1_vld;
  logic [DATA_WIDTH-1:0]   s1_dat;
  logic                    s1_err;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign idx      = req_addr[IDX_W-1:0];

  // Control FSM: clear sweep after reset, then serve requests; ready/busy are registered alongside the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_cnt <= '0;
      req_ready <= (CLEAR_ON_RESET == 0);
      busy      <= (CLEAR_ON_RESET != 0);
    end else if (state == ST_CLEAR) begin
      clear_cnt <= clear_cnt + 1'b1;
      if (clear_cnt == LAST_IDX) begin
        state     <= ST_RUN;
        clear_cnt <= '0;
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

  // Array write port: clear sweep zeroes one word per edge, otherwise byte-masked writes of accepted requests.
  // Gated by resetn so nothing is written while reset is held.
  always_ff @(posedge clock) begin
    if (resetn && state == ST_CLEAR) begin
      mem[clear_cnt] <= '0;
    end else if (resetn && accept && req_wren && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // First response stage: samples the array at acceptance (pre-write contents), zero data for writes/errors.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
      s1_err <= 1'b0;
    end else begin
      s1_vld <= accept;
      s1_err <= accept && !in_range;
      s1_dat <= (accept && !req_wren && in_range) ? mem[idx] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld;
      logic [DATA_WIDTH-1:0] s2_dat;
      logic                  s2_err;

      // Second response stage: plain delay of stage one for the two-cycle configuration.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
          s2_err <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          s2_dat <= s1_dat;
          s2_err <= s1_err;
        end
      end

      assign rsp_valid = s2_vld;
      assign rsp_rdata = s2_dat;
      assign rsp_err   = s2_err;
    end else begin : g_lat1
      assign rsp_valid = s1_vld;
      assign rsp_rdata = s1_dat;
      assign rsp_err   = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_ram_o9_ctrl.sv
// Bench for ram_o9_ctrl: two 16-word instances (latency 1 and 2) share one request stream.
// A word-array model with per-instance response queues predicts every response cycle.
// Directed sequences (clear, byte enables, range errors, resets) are followed by random traffic.
module tb_ram_o9_ctrl;

  localparam int DEPTH = 16;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_wren;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rdy_a, vld_a, err_a, busy_a;
  logic [31:0] dat_a;
  logic        rdy_b, vld_b, err_b, busy_b;
  logic [31:0] dat_b;

  ram_o9_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy_a), .req_wren(req_wren),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld_a), .rsp_rdata(dat_a),
    .rsp_err(err_a), .busy(busy_a));

  ram_o9_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy_b), .req_wren(req_wren),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld_b), .rsp_rdata(dat_b),
    .rsp_err(err_b), .busy(busy_b));

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model_mem [DEPTH];
  int          ncyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Response monitor: each falling edge is one response cycle; compare both instances to their queues.
  always @(negedge clock) begin
    exp_t e;
    ncyc++;
    if (qa.size() > 0 && qa[0].due == ncyc) begin
      e = qa.pop_front();
      check("a_vld", {31'b0, vld_a}, 32'd1);
      check("a_rdata", dat_a, e.dat);
      check("a_err", {31'b0, err_a}, {31'b0, e.err});
    end else begin
      check("a_idle", {31'b0, vld_a}, 32'd0);
    end
    if (qb.size() > 0 && qb[0].due == ncyc) begin
      e = qb.pop_front();
      check("b_vld", {31'b0, vld_b}, 32'd1);
      check("b_rdata", dat_b, e.dat);
      check("b_err", {31'b0, err_b}, {31'b0, e.err});
    end else begin
      check("b_idle", {31'b0, vld_b}, 32'd0);
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_rdy_a"}, {31'b0, rdy_a}, 32'd0);
    check({tag, "_busy_a"}, {31'b0, busy_a}, 32'd1);
    check({tag, "_vld_a"}, {31'b0, vld_a}, 32'd0);
    check({tag, "_dat_a"}, dat_a, 32'd0);
    check({tag, "_err_a"}, {31'b0, err_a}, 32'd0);
    check({tag, "_rdy_b"}, {31'b0, rdy_b}, 32'd0);
    check({tag, "_busy_b"}, {31'b0, busy_b}, 32'd1);
    check({tag, "_vld_b"}, {31'b0, vld_b}, 32'd0);
    check({tag, "_dat_b"}, dat_b, 32'd0);
    check({tag, "_err_b"}, {31'b0, err_b}, 32'd0);
  endtask

  // Assert reset shortly after a rising edge; anything in flight is forgotten.
  task automatic assert_reset(input string tag);
    #2;
    resetn    = 1'b0;
    req_valid = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check_reset(tag);
  endtask

  // Release reset and follow the sweep edge by edge; abort_edge > 0 re-asserts reset at that edge.
  task automatic sweep(input int abort_edge);
    @(negedge clock);
    resetn = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      @(posedge clock);
      if (e == abort_edge) begin
        assert_reset("abort");
        return;
      end
      #1;
      check("sweep_rdy_a", {31'b0, rdy_a}, {31'b0, e == DEPTH});
      check("sweep_busy_a", {31'b0, busy_a}, {31'b0, e != DEPTH});
      check("sweep_rdy_b", {31'b0, rdy_b}, {31'b0, e == DEPTH});
      check("sweep_busy_b", {31'b0, busy_b}, {31'b0, e != DEPTH});
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  // One request, driven at a falling edge and accepted on the next rising edge.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    req_valid = 1'b1;
    req_wren  = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    check("req_rdy_a", {31'b0, rdy_a}, 32'd1);
    check("req_rdy_b", {31'b0, rdy_b}, 32'd1);
    @(posedge clock);
    e.err = (addr >= DEPTH);
    e.dat = 32'd0;
    if (addr < DEPTH) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[addr][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.dat = model_mem[addr];
      end
    end
    e.due = ncyc + 1;
    qa.push_back(e);
    e.due = ncyc + 2;
    qb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Idle cycle with junk on the request lines, which must be ignored.
  task automatic idle_junk();
    req_valid = 1'b0;
    req_wren  = 1'b1;
    req_addr  = 16'($urandom_range(0, DEPTH - 1));
    req_wdata = $urandom;
    req_be    = 4'hF;
    @(negedge clock);
  endtask

  initial begin
    resetn    = 1'b1;
    req_valid = 1'b0;
    req_wren  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    #1 resetn = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clock);
    sweep(0);

    // Cleared contents read as zero.
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, 16'(a), 32'd0, 4'h0);
    idle_junk();

    // Byte enables.
    do_req(1'b1, 16'd5, 32'hAABBCCDD, 4'b1111);
    do_req(1'b1, 16'd5, 32'h11223344, 4'b0101);
    do_req(1'b0, 16'd5, 32'd0, 4'h0);
    do_req(1'b1, 16'd5, 32'hFFFFFFFF, 4'b0000);
    do_req(1'b0, 16'd5, 32'd0, 4'h0);
    idle_junk();

    // Back-to-back reads of value = address.
    for (int a = 0; a < 8; a++) do_req(1'b1, 16'(a), 32'(a), 4'hF);
    for (int a = 0; a < 8; a++) do_req(1'b0, 16'(a), 32'd0, 4'h0);
    idle_junk();

    // Out-of-range accesses, last word must be untouched.
    do_req(1'b1, 16'(DEPTH), 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 16'(DEPTH + 3), 32'd0, 4'h0);
    do_req(1'b0, 16'(DEPTH - 1), 32'd0, 4'h0);
    do_req(1'b0, 16'hFFFF, 32'd0, 4'h0);

    // Read-after-write on consecutive cycles.
    do_req(1'b1, 16'd3, 32'h00001234, 4'hF);
    do_req(1'b0, 16'd3, 32'd0, 4'h0);
    idle_junk();

    // Reset with a response in flight, then a full sweep.
    req_valid = 1'b1;
    req_wren  = 1'b0;
    req_addr  = 16'd3;
    @(posedge clock);
    assert_reset("pipe");
    repeat (2) @(negedge clock);
    sweep(0);
    for (int a = 0; a < 8; a++) do_req(1'b0, 16'(a), 32'd0, 4'h0);

    // Reset mid-sweep at edge 7, then a full restart.
    @(posedge clock);
    assert_reset("pre");
    repeat (2) @(negedge clock);
    sweep(7);
    repeat (2) @(negedge clock);
    sweep(0);

    // Random traffic including out-of-range addresses and idle gaps.
    for (int k = 0; k < 300; k++) begin
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH + 3)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle_junk();
    end

    repeat (4) @(negedge clock);
    #1;
    check("drain_a", qa.size(), 32'd0);
    check("drain_b", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
